// File: rtl/sfx_sequencer_pkg.sv
// sfx_pkg: segment record, effect ids and the production and bench effect tables.
package sfx_pkg;

   localparam int SFX_CLK_HZ = 50_000_000;
   localparam int SFX_NUM    = 4;
   localparam int SFX_SEGS   = 4;
   localparam int SFX_DIV_W  = 18;
   localparam int SFX_DUR_W  = 24;

   localparam int SFX_CAR  = 0;
   localparam int SFX_WIN  = 1;
   localparam int SFX_LOSE = 2;
   localparam int SFX_HOP  = 3;

   typedef struct packed {
      logic [SFX_DIV_W-1:0] half_period;
      logic [SFX_DUR_W-1:0] duration;
      logic                 last;
   } sfx_seg_t;

   function automatic int unsigned hz_to_half(input int unsigned clk_hz, input int unsigned f);
      return (f == 0) ? 0 : clk_hz / (2 * f);
   endfunction

   function automatic sfx_seg_t mk_seg(input int unsigned half, input int unsigned cyc, input logic last);
      sfx_seg_t s;
      s.half_period = SFX_DIV_W'(half);
      s.duration    = SFX_DUR_W'(cyc);
      s.last        = last;
      return s;
   endfunction

   // Unused slots are one-cycle silences flagged last, so a stray index ends cleanly.
   function automatic sfx_seg_t prod_entry(input int unsigned clk_hz, input int sfx, input int seg);
      int unsigned ms;
      sfx_seg_t    s;
      ms = clk_hz / 1000;
      s  = mk_seg(0, 1, 1'b1);
      if (sfx < SFX_NUM && seg < SFX_SEGS) begin
         case (sfx * SFX_SEGS + seg)
            SFX_CAR*SFX_SEGS + 0:  s = mk_seg(hz_to_half(clk_hz, 150),   80 * ms, 1'b0);
            SFX_CAR*SFX_SEGS + 1:  s = mk_seg(hz_to_half(clk_hz, 100),  120 * ms, 1'b1);
            SFX_WIN*SFX_SEGS + 0:  s = mk_seg(hz_to_half(clk_hz, 523),  100 * ms, 1'b0);
            SFX_WIN*SFX_SEGS + 1:  s = mk_seg(hz_to_half(clk_hz, 659),  100 * ms, 1'b0);
            SFX_WIN*SFX_SEGS + 2:  s = mk_seg(hz_to_half(clk_hz, 784),  100 * ms, 1'b0);
            SFX_WIN*SFX_SEGS + 3:  s = mk_seg(hz_to_half(clk_hz, 1047), 250 * ms, 1'b1);
            SFX_LOSE*SFX_SEGS + 0: s = mk_seg(hz_to_half(clk_hz, 392),  150 * ms, 1'b0);
            SFX_LOSE*SFX_SEGS + 1: s = mk_seg(0,                         50 * ms, 1'b0);
            SFX_LOSE*SFX_SEGS + 2: s = mk_seg(hz_to_half(clk_hz, 330),  150 * ms, 1'b0);
            SFX_LOSE*SFX_SEGS + 3: s = mk_seg(hz_to_half(clk_hz, 262),  300 * ms, 1'b1);
            SFX_HOP*SFX_SEGS + 0:  s = mk_seg(hz_to_half(clk_hz, 880),   40 * ms, 1'b1);
            default: ;
         endcase
      end
      return s;
   endfunction

   function automatic sfx_seg_t tb_entry(input int sfx, input int seg);
      sfx_seg_t s;
      s = mk_seg(0, 1, 1'b1);
      if (sfx < SFX_NUM && seg < SFX_SEGS) begin
         case (sfx * SFX_SEGS + seg)
            0:            s = mk_seg(4, 16, 1'b0);
            1:            s = mk_seg(0,  8, 1'b0);
            2:            s = mk_seg(2,  8, 1'b1);
            SFX_SEGS + 0: s = mk_seg(3,  6, 1'b1);
            default: ;
         endcase
      end
      return s;
   endfunction

   localparam sfx_seg_t SFX_TABLE [SFX_NUM][SFX_SEGS] = '{
      '{prod_entry(SFX_CLK_HZ, 0, 0), prod_entry(SFX_CLK_HZ, 0, 1), prod_entry(SFX_CLK_HZ, 0, 2), prod_entry(SFX_CLK_HZ, 0, 3)},
      '{prod_entry(SFX_CLK_HZ, 1, 0), prod_entry(SFX_CLK_HZ, 1, 1), prod_entry(SFX_CLK_HZ, 1, 2), prod_entry(SFX_CLK_HZ, 1, 3)},
      '{prod_entry(SFX_CLK_HZ, 2, 0), prod_entry(SFX_CLK_HZ, 2, 1), prod_entry(SFX_CLK_HZ, 2, 2), prod_entry(SFX_CLK_HZ, 2, 3)},
      '{prod_entry(SFX_CLK_HZ, 3, 0), prod_entry(SFX_CLK_HZ, 3, 1), prod_entry(SFX_CLK_HZ, 3, 2), prod_entry(SFX_CLK_HZ, 3, 3)}
   };

   localparam sfx_seg_t SFX_TABLE_TB [SFX_NUM][SFX_SEGS] = '{
      '{tb_entry(0, 0), tb_entry(0, 1), tb_entry(0, 2), tb_entry(0, 3)},
      '{tb_entry(1, 0), tb_entry(1, 1), tb_entry(1, 2), tb_entry(1, 3)},
      '{tb_entry(2, 0), tb_entry(2, 1), tb_entry(2, 2), tb_entry(2, 3)},
      '{tb_entry(3, 0), tb_entry(3, 1), tb_entry(3, 2), tb_entry(3, 3)}
   };

endpackage

// File: rtl/sfx_sequencer_if.sv
// sfx_sequencer_if: game-side trigger/mute inputs and speaker/status outputs of the sequencer.
interface sfx_sequencer_if
   import sfx_pkg::*;
#(
   parameter int NUM_SFX = SFX_NUM
);
   localparam int ID_W = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1;

   logic [NUM_SFX-1:0] trigger;
   logic               mute;
   logic               soundOut;
   logic               busy;
   logic [ID_W-1:0]    activeId;
   logic               done;

   modport master (output trigger, output mute, input soundOut, input busy, input activeId, input done);
   modport slave  (input trigger, input mute, output soundOut, output busy, output activeId, output done);
endinterface

// File: rtl/sfx_sequencer_tone_gen.sv
// tone_gen: half-period divider with a toggle register and a muted, registered speaker output.
module tone_gen #(
   parameter int DIV_W = 18
)(
   input  logic             clk,
   input  logic             resetN,
   input  logic             restart,
   input  logic             run,
   input  logic             mute,
   input  logic [DIV_W-1:0] half_period,
   output logic             sound
);
   logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
   logic             phase_reg, phase_next, sound_reg;

   // Neither restarting nor running means the output parks low with the divider cleared.
   always_comb begin
      div_cnt_next = '0;
      phase_next   = 1'b0;
      if (restart) begin
         phase_next = (half_period != '0);
      end else if (run && half_period != '0) begin
         if (div_cnt_reg == half_period - 1'b1) begin
            phase_next = ~phase_reg;
         end else begin
            div_cnt_next = div_cnt_reg + 1'b1;
            phase_next   = phase_reg;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         div_cnt_reg <= '0;
         phase_reg   <= 1'b0;
         sound_reg   <= 1'b0;
      end else begin
         div_cnt_reg <= div_cnt_next;
         phase_reg   <= phase_next;
         sound_reg   <= phase_next & ~mute;
      end
   end

   assign sound = sound_reg;
endmodule

// File: rtl/sfx_sequencer.sv
// sfx_sequencer: trigger-edge driven multi-segment sound effect player on one speaker bit.
// Optional macro SFX_PREEMPT_EN: same/higher-priority edges abort the playing effect.
module sfx_sequencer
   import sfx_pkg::*;
#(
   parameter int CLK_HZ    = SFX_CLK_HZ,
   parameter int NUM_SFX   = SFX_NUM,
   parameter int MAX_SEGS  = SFX_SEGS,
   parameter int DIV_W     = SFX_DIV_W,
   parameter int DUR_W     = SFX_DUR_W,
   parameter int TABLE_SEL = 0
)(
   input logic            clk,
   input logic            resetN,
   sfx_sequencer_if.slave bus
);
   localparam int ID_W  = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1;
   localparam int SEG_W = (MAX_SEGS > 1) ? $clog2(MAX_SEGS) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_PLAY = 2'd2;

   logic [1:0]         state_reg, state_next;
   logic [NUM_SFX-1:0] trig_q_reg, trig_edge;
   logic [ID_W-1:0]    active_id_reg, active_id_next, first_idx;
   logic [SEG_W-1:0]   seg_idx_reg, seg_idx_next;
   logic [DUR_W-1:0]   dur_cnt_reg, dur_cnt_next, dur_last;
   logic               done_reg, done_next;
   logic               any_edge, seg_end, seg_final, abort, load_go;
   logic               tone_restart, tone_run;
   sfx_seg_t           seg_reg;
   sfx_seg_t           rom [NUM_SFX][MAX_SEGS];

   // Production entries are recomputed when CLK_HZ differs from the package clock.
   for (genvar gi = 0; gi < NUM_SFX; gi++) begin : g_sfx
      for (genvar gj = 0; gj < MAX_SEGS; gj++) begin : g_seg
         if (TABLE_SEL == 1 && gi < SFX_NUM && gj < SFX_SEGS) begin : g_tb
            assign rom[gi][gj] = SFX_TABLE_TB[gi][gj];
         end else if (TABLE_SEL == 1) begin : g_tb_pad
            assign rom[gi][gj] = tb_entry(gi, gj);
         end else if (CLK_HZ == SFX_CLK_HZ && gi < SFX_NUM && gj < SFX_SEGS) begin : g_prod
            assign rom[gi][gj] = SFX_TABLE[gi][gj];
         end else begin : g_prod_clk
            assign rom[gi][gj] = prod_entry(CLK_HZ, gi, gj);
         end
      end
   end

   for (genvar gi = 0; gi < NUM_SFX; gi++) begin : g_edge
      assign trig_edge[gi] = bus.trigger[gi] & ~trig_q_reg[gi];
   end

   always_comb begin
      first_idx = '0;
      for (int i = NUM_SFX - 1; i >= 0; i--) begin
         if (trig_edge[i]) first_idx = ID_W'(i);
      end
   end

   assign any_edge  = |trig_edge;
   assign dur_last  = (seg_reg.duration == '0) ? '0 : DUR_W'(seg_reg.duration - 1'b1);
   assign seg_end   = (state_reg == ST_PLAY) && (dur_cnt_reg == dur_last);
   assign seg_final = seg_reg.last || (seg_idx_reg == SEG_W'(MAX_SEGS - 1));

`ifdef SFX_PREEMPT_EN
   assign abort = (state_reg != ST_IDLE) && any_edge && (first_idx <= active_id_reg);
`else
   assign abort = 1'b0;
`endif

   always_comb begin
      state_next     = state_reg;
      active_id_next = active_id_reg;
      seg_idx_next   = seg_idx_reg;
      dur_cnt_next   = '0;
      done_next      = 1'b0;
      load_go        = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (any_edge) begin
               active_id_next = first_idx;
               seg_idx_next   = '0;
               state_next     = ST_LOAD;
               load_go        = 1'b1;
            end
         end
         ST_LOAD: state_next = ST_PLAY;
         ST_PLAY: begin
            if (!seg_end) begin
               dur_cnt_next = dur_cnt_reg + 1'b1;
            end else if (seg_final) begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
            end else begin
               seg_idx_next = seg_idx_reg + 1'b1;
               state_next   = ST_LOAD;
               load_go      = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      if (abort) begin
         active_id_next = first_idx;
         seg_idx_next   = '0;
         state_next     = ST_LOAD;
         load_go        = 1'b1;
         done_next      = 1'b0;
         dur_cnt_next   = '0;
      end
   end

   // The segment is fetched on the edge into LOAD so it is stable for the whole LOAD cycle.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_reg     <= ST_IDLE;
         trig_q_reg    <= '1;
         active_id_reg <= '0;
         seg_idx_reg   <= '0;
         dur_cnt_reg   <= '0;
         done_reg      <= 1'b0;
         seg_reg       <= '0;
      end else begin
         state_reg     <= state_next;
         trig_q_reg    <= bus.trigger;
         active_id_reg <= active_id_next;
         seg_idx_reg   <= seg_idx_next;
         dur_cnt_reg   <= dur_cnt_next;
         done_reg      <= done_next;
         if (load_go) seg_reg <= rom[active_id_next][seg_idx_next];
      end
   end

   assign tone_restart = (state_reg == ST_LOAD) && !abort;
   assign tone_run     = (state_reg == ST_PLAY) && !seg_end && !abort;

   tone_gen #(.DIV_W(DIV_W)) u_tone (
      .clk         (clk),
      .resetN      (resetN),
      .restart     (tone_restart),
      .run         (tone_run),
      .mute        (bus.mute),
      .half_period (DIV_W'(seg_reg.half_period)),
      .sound       (bus.soundOut)
   );

   assign bus.busy     = (state_reg != ST_IDLE);
   assign bus.activeId = active_id_reg;
   assign bus.done     = done_reg;
endmodule
